fifo_regs_mc: RTL

Multi-channel successor to the single-FIFO control/status register block. It serves NUM_CH independent FIFO cores from one bus slave. Each channel has its own control, status, almost-full/almost-empty thresholds and a W1C interrupt status/enable pair. The block sits between the bus fabric and an array of FIFO cores, drives a single aggregated level interrupt, and returns read data on a registered one-cycle read path.

---
 rtl/fifo_regs_mc_pkg.sv | 32 +++
 rtl/fifo_regs_ch.sv | 120 ++++++++++++
 rtl/fifo_regs_mc.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_regs_mc_pkg.sv
// Shared register-map constants and types for the multi-channel FIFO register block.
package fifo_regs_mc_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_THRESH = 4'h8;
    localparam logic [3:0] OFF_IRQ    = 4'hC;

    localparam logic [7:0] ADDR_ID      = 8'hF0;
    localparam logic [7:0] ADDR_IRQ_SUM = 8'hF4;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_CLEAR      = 1;
    localparam int CTRL_IRQ_EN_LSB = 8;

    localparam int IRQ_AF_RISE   = 0;
    localparam int IRQ_AE_RISE   = 1;
    localparam int IRQ_OVERFLOW  = 2;
    localparam int IRQ_UNDERFLOW = 3;
    localparam int IRQ_W         = 4;

    localparam logic [15:0] ID_MAGIC = 16'hF1F0;

    // Field order matches the IRQ register layout, af_rise in bit 0.
    typedef struct packed {
        logic underflow;
        logic overflow;
        logic ae_rise;
        logic af_rise;
    } irq_stat_t;

endpackage

// File: rtl/fifo_regs_ch.sv
// One channel's register slice: CTRL, THRESH, threshold edge detectors,
// W1C interrupt status and the channel-local read mux.
module fifo_regs_ch
    import fifo_regs_mc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,
    input  logic [3:0]    offset,
    input  logic          wen,
    input  logic [31:0]   wdata,
    input  logic          empty,
    input  logic          full,
    input  logic [CW-1:0] count,
    input  logic          overflow,
    input  logic          underflow,
    output logic          enable,
    output logic          clear,
    output logic [CW-1:0] af_th,
    output logic [31:0]   rd_data,
    output logic          irq
);

    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

    logic [IRQ_W-1:0] irq_en;
    logic [CW-1:0]    ae_th;
    irq_stat_t        irq_stat;
    irq_stat_t        irq_events;
    irq_stat_t        irq_next;
    logic             af_prev;
    logic             ae_prev;
    logic             almost_full;
    logic             almost_empty;
    logic             wr_ctrl;
    logic             wr_thresh;
    logic             wr_irq;
    logic [IRQ_W-1:0] w1c_mask;
    logic             unused_wdata;

    function automatic logic [CW-1:0] clamp_th(input logic [CW-1:0] v);
        return (v > DEPTH_CW) ? DEPTH_CW : v;
    endfunction

    assign unused_wdata = ^wdata;

    assign wr_ctrl   = sel & wen & (offset == OFF_CTRL);
    assign wr_thresh = sel & wen & (offset == OFF_THRESH);
    assign wr_irq    = sel & wen & (offset == OFF_IRQ);

    assign almost_full  = (count >= af_th);
    assign almost_empty = (count <= ae_th);

    // Events are captured whether or not the channel is enabled; a same-cycle
    // event beats the W1C clear of that bit.
    assign irq_events.af_rise   = almost_full & ~af_prev;
    assign irq_events.ae_rise   = almost_empty & ~ae_prev;
    assign irq_events.overflow  = overflow;
    assign irq_events.underflow = underflow;

    assign w1c_mask = wr_irq ? wdata[IRQ_W-1:0] : '0;
    assign irq_next = irq_stat_t'((irq_stat & ~w1c_mask) | irq_events);

    assign irq = |(irq_stat & irq_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable   <= 1'b0;
            clear    <= 1'b0;
            irq_en   <= '0;
            af_th    <= CW'(DEPTH - 1);
            ae_th    <= '0;
            irq_stat <= '0;
            af_prev  <= 1'b0;
            ae_prev  <= 1'b1;
        end else begin
            clear    <= wr_ctrl & wdata[CTRL_CLEAR];
            irq_stat <= irq_next;
            af_prev  <= almost_full;
            ae_prev  <= almost_empty;
            if (wr_ctrl) begin
                enable <= wdata[CTRL_ENABLE];
                irq_en <= wdata[CTRL_IRQ_EN_LSB +: IRQ_W];
            end
            if (wr_thresh) begin
                af_th <= clamp_th(wdata[CW-1:0]);
                ae_th <= clamp_th(wdata[8 +: CW]);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (offset)
                OFF_CTRL: begin
                    rd_data[CTRL_ENABLE]                 = enable;
                    rd_data[CTRL_IRQ_EN_LSB +: IRQ_W]    = irq_en;
                end
                OFF_STATUS: begin
                    rd_data[0]    = empty;
                    rd_data[1]    = full;
                    rd_data[2]    = almost_full;
                    rd_data[3]    = almost_empty;
                    rd_data[15:8] = 8'(count);
                end
                OFF_THRESH: begin
                    rd_data[CW-1:0]  = af_th;
                    rd_data[8 +: CW] = ae_th;
                end
                OFF_IRQ: rd_data[IRQ_W-1:0] = irq_stat;
                default: rd_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/fifo_regs_mc.sv
// Bus slave serving NUM_CH FIFO register slices with a registered one-cycle
// read path and a single aggregated level interrupt.
module fifo_regs_mc
    import fifo_regs_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 wen,
    input  logic                 ren,
    output logic [DATA_W-1:0]    rdata,
    output logic                 rvalid,
    output logic                 ready,
    output logic                 irq,
    output logic [NUM_CH-1:0]    fifo_enable,
    output logic [NUM_CH-1:0]    fifo_clear,
    output logic [NUM_CH*CW-1:0] af_thresh,
    input  logic [NUM_CH-1:0]    fifo_empty,
    input  logic [NUM_CH-1:0]    fifo_full,
    input  logic [NUM_CH*CW-1:0] fifo_count,
    input  logic [NUM_CH-1:0]    fifo_overflow,
    input  logic [NUM_CH-1:0]    fifo_underflow
);

    logic [7:0]        reg_addr;
    logic [31:0]       wdata32;
    logic [31:0]       ch_rd [NUM_CH];
    logic [NUM_CH-1:0] irq_vec;
    logic [31:0]       rd_mux;
    logic              unused_addr;

    assign reg_addr    = addr[7:0];
    assign wdata32     = 32'(wdata);
    assign unused_addr = ^addr;
    assign ready       = 1'b1;
    assign irq         = |irq_vec;

    // Channel index >= NUM_CH (including the 0xF0 global page) never matches a slice.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_regs_ch #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .sel       (reg_addr[7:4] == 4'(c)),
            .offset    (reg_addr[3:0]),
            .wen       (wen),
            .wdata     (wdata32),
            .empty     (fifo_empty[c]),
            .full      (fifo_full[c]),
            .count     (fifo_count[c*CW +: CW]),
            .overflow  (fifo_overflow[c]),
            .underflow (fifo_underflow[c]),
            .enable    (fifo_enable[c]),
            .clear     (fifo_clear[c]),
            .af_th     (af_thresh[c*CW +: CW]),
            .rd_data   (ch_rd[c]),
            .irq       (irq_vec[c])
        );
    end

    always_comb begin
        rd_mux = '0;
        if (reg_addr == ADDR_ID) begin
            rd_mux = {ID_MAGIC, 8'(CW), 8'(NUM_CH)};
        end else if (reg_addr == ADDR_IRQ_SUM) begin
            rd_mux = 32'(irq_vec);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (reg_addr[7:4] == 4'(c)) begin
                    rd_mux = ch_rd[c];
                end
            end
        end
    end

    // Sampling pre-edge state means a same-cycle write is seen only by later reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) begin
                rdata <= DATA_W'(rd_mux);
            end
        end
    end

endmodule
